clock_delay_cal_m: RTL

Calibration sequencer for the programmable clock delay line. It puts the delay line into ring-oscillator mode and sweeps the oscillating delay settings, counting oscillator edges over a fixed window of system clocks. It then selects the shortest setting whose measured delay meets a programmed target and hands the line back to normal delayed-clock operation. A manual override bypasses calibration entirely.

---
 rtl/clock_delay_cal_m.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/clock_delay_cal_m.sv
// clock_delay_cal_m: calibration sequencer for the programmable clock delay line.
// Sweeps ring-oscillator settings 4..6, counts oscillator edges over a window of
// 2^WINDOW_LOG2 ck_ip cycles, and keeps the shortest setting whose count is at
// or below target_ip. manual_ip bypasses calibration.
// Build macro CLKDEL_CAL_AVG_EN: two back-to-back windows per tap, averaged.
//
// state   | meaning
// IDLE    | waiting for start_ip; line in normal delayed-clock mode
// SETTLE  | oscillator enabled at current tap, 16 cycles, edges ignored
// MEASURE | edge counter running for the window
// EVAL    | compare count with target, pick tap or advance sweep
// RESTORE | oscillator off, 16 cycles for the line to flush
// DONE    | one-cycle completion pulse
module clock_delay_cal_m #(
  parameter int WINDOW_LOG2 = 10,
  parameter int CNT_W       = 12
) (
  input  logic             ck_ip,
  input  logic             rst_ip,
  input  logic             start_ip,
  input  logic [CNT_W-1:0] target_ip,
  input  logic             rosc_fb_ip,
  input  logic             manual_ip,
  input  logic [2:0]       man_del_ip,
  output logic [2:0]       intdel_op,
  output logic             rosc_op,
  output logic             cksel_op,
  output logic             busy_op,
  output logic             done_op,
  output logic             fail_op,
  output logic [2:0]       result_op,
  output logic [CNT_W-1:0] count_op
);

  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, EVAL, RESTORE, DONE} state_t;

  localparam int TMR_W = (WINDOW_LOG2 > 4) ? WINDOW_LOG2 : 4;
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(15);
  localparam logic [TMR_W-1:0] WIN_LOAD    = TMR_W'((1 << WINDOW_LOG2) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_t           state, state_n;
  logic [TMR_W-1:0] tmr, tmr_n;
  logic [2:0]       tap, tap_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_upd, meas;
  logic             calibrated, cal_n;
  logic             sync1, sync2, sync3, edge_det;
  logic [2:0]       result_n, intdel_n;
  logic [CNT_W-1:0] count_n;
  logic             fail_n, rosc_n, cksel_n, busy_n, done_n, in_cal;
`ifdef CLKDEL_CAL_AVG_EN
  logic [CNT_W:0]   sum, sum_n, sum_tot;
  logic             second_pass, second_n;
`endif

  // Bring the asynchronous oscillator tap into ck_ip and keep one delayed copy for edge detect.
  always_ff @(posedge ck_ip) begin
    if (rst_ip) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= rosc_fb_ip;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign edge_det = sync2 & ~sync3;
  assign cnt_upd  = (edge_det && (cnt != CNT_MAX)) ? cnt + 1'b1 : cnt;

`ifdef CLKDEL_CAL_AVG_EN
  assign sum_tot = sum + {1'b0, cnt};
  assign meas    = sum_tot[CNT_W:1];
`else
  assign meas    = cnt;
`endif

  // Next-state, sweep bookkeeping and next values of every registered output.
  always_comb begin
    state_n  = state;
    tmr_n    = tmr;
    tap_n    = tap;
    cnt_n    = cnt;
    cal_n    = calibrated;
    result_n = result_op;
    fail_n   = fail_op;
    count_n  = count_op;
`ifdef CLKDEL_CAL_AVG_EN
    sum_n    = sum;
    second_n = second_pass;
`endif
    case (state)
      IDLE: begin
        if (start_ip && !manual_ip) begin
          state_n = SETTLE;
          tap_n   = 3'd4;
          tmr_n   = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (tmr != '0) tmr_n = tmr - 1'b1;
        else begin
          state_n = MEASURE;
          tmr_n   = WIN_LOAD;
          cnt_n   = '0;
`ifdef CLKDEL_CAL_AVG_EN
          second_n = 1'b0;
`endif
        end
      end
      MEASURE: begin
        cnt_n = cnt_upd;
        if (tmr != '0) tmr_n = tmr - 1'b1;
        else begin
`ifdef CLKDEL_CAL_AVG_EN
          if (!second_pass) begin
            second_n = 1'b1;
            sum_n    = {1'b0, cnt_upd};
            cnt_n    = '0;
            tmr_n    = WIN_LOAD;
          end else begin
            state_n = EVAL;
          end
`else
          state_n = EVAL;
`endif
        end
      end
      EVAL: begin
        count_n = meas;
        if (meas <= target_ip) begin
          result_n = tap;
          fail_n   = 1'b0;
          state_n  = RESTORE;
          tmr_n    = SETTLE_LOAD;
        end else if (tap < 3'd6) begin
          tap_n   = tap + 1'b1;
          state_n = SETTLE;
          tmr_n   = SETTLE_LOAD;
        end else begin
          result_n = 3'd6;
          fail_n   = 1'b1;
          state_n  = RESTORE;
          tmr_n    = SETTLE_LOAD;
        end
      end
      RESTORE: begin
        if (tmr != '0) tmr_n = tmr - 1'b1;
        else begin
          state_n = DONE;
          cal_n   = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Override wins from any state and leaves the previous calibration untouched.
    if (manual_ip) begin
      state_n  = IDLE;
      cal_n    = calibrated;
      result_n = result_op;
      fail_n   = fail_op;
      count_n  = count_op;
    end

    in_cal = (state_n == SETTLE) || (state_n == MEASURE) ||
             (state_n == EVAL)   || (state_n == RESTORE);
    busy_n = in_cal;
    done_n = (state_n == DONE);
    rosc_n = (state_n == SETTLE) || (state_n == MEASURE) || (state_n == EVAL);
    if (in_cal) begin
      intdel_n = tap_n;
      cksel_n  = 1'b0;
    end else if (manual_ip) begin
      intdel_n = man_del_ip;
      cksel_n  = 1'b1;
    end else if (cal_n) begin
      intdel_n = result_n;
      cksel_n  = 1'b1;
    end else begin
      intdel_n = 3'd0;
      cksel_n  = 1'b0;
    end
  end

  // State, timer, counter and all outputs registered together.
  always_ff @(posedge ck_ip) begin
    if (rst_ip) begin
      state      <= IDLE;
      tmr        <= '0;
      tap        <= 3'd0;
      cnt        <= '0;
      calibrated <= 1'b0;
      intdel_op  <= 3'd0;
      rosc_op    <= 1'b0;
      cksel_op   <= 1'b0;
      busy_op    <= 1'b0;
      done_op    <= 1'b0;
      fail_op    <= 1'b0;
      result_op  <= 3'd0;
      count_op   <= '0;
`ifdef CLKDEL_CAL_AVG_EN
      sum         <= '0;
      second_pass <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      tmr        <= tmr_n;
      tap        <= tap_n;
      cnt        <= cnt_n;
      calibrated <= cal_n;
      intdel_op  <= intdel_n;
      rosc_op    <= rosc_n;
      cksel_op   <= cksel_n;
      busy_op    <= busy_n;
      done_op    <= done_n;
      fail_op    <= fail_n;
      result_op  <= result_n;
      count_op   <= count_n;
`ifdef CLKDEL_CAL_AVG_EN
      sum         <= sum_n;
      second_pass <= second_n;
`endif
    end
  end

endmodule
